fir_engine_mc: RTL and testbench
================================

Name: fir_engine_mc

Overview:
Parametrised multi-channel FIR core: the next generation of the FIR engine datapath. One shared MAC is time-multiplexed across NChannels independent sample histories, with a serially loaded coefficient bank and an optional symmetric (pre-add) mode. Output is saturated and reported with a channel tag. It sits between the I2S controller (start/x) and the DAC path (done/y), with coefficients shifted in from the config store's serial stream.

Parameters:
NChannels, 2, number of independent sample histories (≥1)
NTaps, 9, filter length (≥2)
DataWidth, 12, signed sample width in and out
CoeffWidth, 12, signed coefficient width, Q1.(CoeffWidth-1)

Ports:
clk  in  1  single clock, all logic rising-edge
resetN  in  1  asynchronous active-low reset
start  in  1  one-cycle sample-valid strobe
chSel  in  max(1,$clog2(NChannels))  channel of x
x  in  DataWidth  signed input sample
symCoeffs  in  1  1 = symmetric mode, sampled at accepted start
lock  in  1  coefficient-write window; results muted while high
coeffLoadEn  in  1  serial coefficient shift enable
coeffIn  in  1  serial coefficient bit, MSB-first
busy  out  1  high while state != IDLE
done  out  1  one-cycle result-valid pulse
doneCh  out  width(chSel)  channel of y, valid with done
y  out  DataWidth  signed result, held until next done
overrun  out  1  one-cycle pulse: start dropped

Behaviour:
- Reset (async, resetN=0): histories, coefficients, head pointers, accumulator cleared; y=0, done=0, doneCh=0, busy=0, overrun=0; FSM=IDLE. Reset mid-operation aborts; no done pulse is issued.
- Coefficients: chain {c[0]..c[NTaps-1]}, NTaps*CoeffWidth bits. Each cycle with lock=1 && coeffLoadEn=1: chain shifts left 1, coeffIn enters LSB of c[NTaps-1], c[0] MSB discarded. After NTaps*CoeffWidth bits MSB-first, the first word sent sits in c[0]. coeffLoadEn ignored when lock=0. Shifting proceeds independently of FSM state.
- History: per channel, an NTaps-deep circular buffer with its own head pointer (wraps at NTaps). Tap k = sample k steps ago (k=0 newest).
- FSM IDLE: start=1, chSel<NChannels → write x at channel head (oldest overwritten), latch channel and symCoeffs, clear acc, clear mute flag, go MAC. chSel≥NChannels → start ignored, no done, no overrun.
- FSM MAC: one tap per cycle. Normal: acc += h[k]*c[k], k=0..NTaps-1, M=NTaps cycles. Symmetric: M=ceil(NTaps/2); for k<floor(NTaps/2), acc += (h[k]+h[NTaps-1-k])*c[k]; for odd NTaps, centre acc += h[mid]*c[mid]. The pre-add is DataWidth+1 bits. lock=1 on any MAC cycle (or at the accepting start) sets mute.
- FSM OUT: y = mute ? 0 : sat(acc >>> (CoeffWidth-1)) to [-2^(DataWidth-1), 2^(DataWidth-1)-1]; done=1, doneCh=latched channel; go IDLE.
- Acc width: DataWidth+CoeffWidth+$clog2(NTaps)+1; no internal overflow.
- Latency: start accepted at edge E0 → done high for the one cycle following edge E(M+1). busy high from E0+ through the done cycle.
- start while busy: dropped, history unchanged, overrun=1 next cycle. start coincident with done cycle is also dropped.
- symCoeffs and chSel changes mid-computation have no effect.

Optional Feature:
FIR_ROUND_EN: defined → round half-up: acc + 2^(CoeffWidth-2) before the arithmetic shift, then saturate. Undefined → plain truncation (floor). Latency is identical in both builds.

Test Plan:
- Impulse: load c[0..8]={1024,512,256,0×6}, ch0 x=1000 then 0,0,0 → y=500,250,125,0; doneCh=0; done exactly 10 cycles after each accepted start.
- Channel isolation: interleave ch0 impulse 1000 with ch1 x=0 stream → ch1 y=0 throughout, ch0 y as above, doneCh alternates 0/1.
- Symmetric: symCoeffs=1, c[0..4]={512,0,0,0,1024}, ch0 impulse 800 → y=200,0,0,0,400,0,0,0,200; done 6 cycles after start.
- Saturation: c[0]=c[1]=2047, x=2047 twice → y=2047; x=-2048 twice → y=-2048.
- Lock/mute: assert lock during MAC → done at normal time with y=0. Shift 108 bits under lock → new coefficients used on the next start.
- Overrun/reset: start while busy → overrun pulse, single done. resetN low mid-MAC → no done, y=0. Rounding build: x=3, c[0]=1024 → y=2 (truncating build y=1); x=-3 → y=-1 (truncating -2).

Source files
------------

// File: rtl/fir_engine_mc.sv
// fir_engine_mc: multi-channel FIR, one shared MAC time-multiplexed over per-channel sample histories.
// Latency: start accepted at edge E0 -> done high in the cycle after edge E(M+1), M = NTaps (normal) or ceil(NTaps/2) (symmetric).
// Backpressure: none; start while busy (including the done cycle) is dropped and flagged by a one-cycle overrun pulse.
//
// Ports:
//   clk, resetN              clock (rising edge), asynchronous active-low reset
//   start, chSel, x          sample strobe, target channel, signed sample
//   symCoeffs                symmetric (pre-add) mode, captured when start is accepted
//   lock                     coefficient write window; a result computed while lock is seen is muted to 0
//   coeffLoadEn, coeffIn     serial coefficient shift (MSB-first), only effective while lock=1
//   busy, done, doneCh, y    engine busy, result strobe, result channel, saturated signed result
//   overrun                  one-cycle pulse when a start is dropped
//
// Build option: define FIR_ROUND_EN for round-half-up before the output shift; otherwise truncation (floor).

module fir_engine_mc #(
  parameter int NChannels  = 2,
  parameter int NTaps      = 9,
  parameter int DataWidth  = 12,
  parameter int CoeffWidth = 12,
  localparam int ChW       = (NChannels > 1) ? $clog2(NChannels) : 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic [ChW-1:0]       chSel,
  input  logic [DataWidth-1:0] x,
  input  logic                 symCoeffs,
  input  logic                 lock,
  input  logic                 coeffLoadEn,
  input  logic                 coeffIn,
  output logic                 busy,
  output logic                 done,
  output logic [ChW-1:0]       doneCh,
  output logic [DataWidth-1:0] y,
  output logic                 overrun
);

  localparam int PtrW   = $clog2(NTaps);
  localparam int KW     = $clog2(NTaps + 1);
  localparam int AccW   = DataWidth + CoeffWidth + $clog2(NTaps) + 1;
  localparam int PreW   = DataWidth + 1;
  localparam int ProdW  = PreW + CoeffWidth;
  localparam int ChainW = NTaps * CoeffWidth;

  localparam logic [KW-1:0]   LastNorm = KW'(NTaps - 1);
  localparam logic [KW-1:0]   LastSym  = KW'((NTaps + 1) / 2 - 1);
  localparam logic [KW-1:0]   HalfK    = KW'(NTaps / 2);
  localparam logic [ChW:0]    NumCh    = (ChW + 1)'(NChannels);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(NTaps - 1);

  localparam logic signed [AccW-1:0] YMax = AccW'((1 << (DataWidth - 1)) - 1);
  localparam logic signed [AccW-1:0] YMin = AccW'(-(1 << (DataWidth - 1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT, HOLD} state_t;

  state_t                      state;
  logic [ChainW-1:0]           chain;
  logic signed [DataWidth-1:0] hist [NChannels][NTaps];
  logic [PtrW-1:0]             head [NChannels];
  logic [ChW-1:0]              ch_q;
  logic                        sym_q;
  logic                        mute;
  logic [KW-1:0]               k;
  logic [KW-1:0]               k_last;
  logic [PtrW-1:0]             rp_new;   // walks from newest sample towards older ones
  logic [PtrW-1:0]             rp_old;   // walks from oldest sample towards newer ones (symmetric partner)
  logic signed [AccW-1:0]      acc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? LastPtr : p - 1'b1;
  endfunction

  // Coefficient c[k] lives at the k-th word from the MSB end of the chain.
  logic signed [CoeffWidth-1:0] coef;
  always_comb begin
    coef = '0;
    for (int i = 0; i < NTaps; i++) begin
      if (k == KW'(i)) coef = chain[(NTaps - i) * CoeffWidth - 1 -: CoeffWidth];
    end
  end

  logic signed [DataWidth-1:0] h_new;
  logic signed [DataWidth-1:0] h_old;
  assign h_new = hist[ch_q][rp_new];
  assign h_old = hist[ch_q][rp_old];

  logic signed [PreW-1:0]  pre;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  prod_ext;
  always_comb begin
    pre = PreW'(h_new);
    // Symmetric mode pairs tap k with tap NTaps-1-k; the odd centre tap is taken alone.
    if (sym_q && (k < HalfK)) pre = PreW'(h_new) + PreW'(h_old);
    prod     = ProdW'(pre) * ProdW'(coef);
    prod_ext = AccW'(prod);
  end

  logic signed [AccW-1:0] acc_adj;
`ifdef FIR_ROUND_EN
  localparam logic signed [AccW-1:0] RndBias = AccW'(1 << (CoeffWidth - 2));
  assign acc_adj = acc + RndBias;
`else
  assign acc_adj = acc;
`endif

  logic signed [AccW-1:0]  shifted;
  logic [DataWidth-1:0]    y_sat;
  assign shifted = acc_adj >>> (CoeffWidth - 1);
  always_comb begin
    if (shifted > YMax)      y_sat = {1'b0, {(DataWidth - 1){1'b1}}};
    else if (shifted < YMin) y_sat = {1'b1, {(DataWidth - 1){1'b0}}};
    else                     y_sat = shifted[DataWidth-1:0];
  end

  // Serial coefficient chain, independent of the FSM.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      chain <= '0;
    end else if (lock && coeffLoadEn) begin
      chain <= {chain[ChainW-2:0], coeffIn};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      doneCh  <= '0;
      y       <= '0;
      overrun <= 1'b0;
      ch_q    <= '0;
      sym_q   <= 1'b0;
      mute    <= 1'b0;
      k       <= '0;
      k_last  <= '0;
      rp_new  <= '0;
      rp_old  <= '0;
      acc     <= '0;
      for (int c = 0; c < NChannels; c++) begin
        head[c] <= '0;
        for (int t = 0; t < NTaps; t++) hist[c][t] <= '0;
      end
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ({1'b0, chSel} < NumCh)) begin
            // head points at the oldest slot: overwrite it, and the slot after it becomes the oldest.
            hist[chSel][head[chSel]] <= x;
            head[chSel] <= ptr_inc(head[chSel]);
            rp_new      <= head[chSel];
            rp_old      <= ptr_inc(head[chSel]);
            ch_q        <= chSel;
            sym_q       <= symCoeffs;
            k_last      <= symCoeffs ? LastSym : LastNorm;
            k           <= '0;
            acc         <= '0;
            mute        <= lock;
            busy        <= 1'b1;
            state       <= MAC;
          end
        end
        MAC: begin
          acc    <= acc + prod_ext;
          k      <= k + 1'b1;
          rp_new <= ptr_dec(rp_new);
          rp_old <= ptr_inc(rp_old);
          if (lock) mute <= 1'b1;
          if (k == k_last) state <= OUT;
        end
        OUT: begin
          y      <= mute ? '0 : y_sat;
          done   <= 1'b1;
          doneCh <= ch_q;
          state  <= HOLD;
        end
        HOLD: begin
          // Done cycle: still busy, so a coincident start is dropped.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (start && (state != IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_engine_mc.sv
module tb_fir_engine_mc;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [0:0]  chSel;
  logic [11:0] x;
  logic        symCoeffs;
  logic        lock;
  logic        coeffLoadEn;
  logic        coeffIn;
  logic        busy;
  logic        done;
  logic [0:0]  doneCh;
  logic [11:0] y;
  logic        overrun;

  always #5 clk = ~clk;

  fir_engine_mc #(
    .NChannels(2), .NTaps(9), .DataWidth(12), .CoeffWidth(12)
  ) dut (
    .clk(clk), .resetN(resetN), .start(start), .chSel(chSel), .x(x),
    .symCoeffs(symCoeffs), .lock(lock), .coeffLoadEn(coeffLoadEn), .coeffIn(coeffIn),
    .busy(busy), .done(done), .doneCh(doneCh), .y(y), .overrun(overrun)
  );

  typedef struct {
    int ch;
    int xv;
    int sym;
    int ey;
    int ech;
    int elat;
  } vec_t;

  vec_t        tv [26];
  int          tests = 0;
  int          fails = 0;
  logic [107:0] cbuf;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_coeffs(input logic [107:0] chain);
    lock = 1'b1;
    coeffLoadEn = 1'b1;
    for (int i = 107; i >= 0; i--) begin
      coeffIn = chain[i];
      @(posedge clk); #1;
    end
    lock = 1'b0;
    coeffLoadEn = 1'b0;
    coeffIn = 1'b0;
  endtask

  // Issue one start and wait (bounded) for done. Returns at #1 after the edge that raised done.
  task automatic do_start(input int ch, input int xv, input int sym, input int lock_at,
                          output int y_o, output int ch_o, output int lat);
    bit got;
    y_o = 0; ch_o = -1; lat = -1; got = 1'b0;
    start = 1'b1; chSel = 1'(ch); x = 12'(xv); symCoeffs = 1'(sym);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      lock = (i == lock_at);
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1; lat = i; y_o = int'($signed(y)); ch_o = int'(doneCh);
      end
    end
    lock = 1'b0;
  endtask

  task automatic run_vec(input int i, input int lock_at);
    int yo, co, lat;
    do_start(tv[i].ch, tv[i].xv, tv[i].sym, lock_at, yo, co, lat);
    chk($sformatf("v%0d_y", i), yo, tv[i].ey);
    chk($sformatf("v%0d_ch", i), co, tv[i].ech);
    chk($sformatf("v%0d_lat", i), lat, tv[i].elat);
    @(posedge clk); #1;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    int n, yo, co, lat;

    // Impulse on ch0 with c = {1024,512,256,0...}
    tv[0]  = '{0, 1000, 0, 500, 0, 10};
    tv[1]  = '{0, 0,    0, 250, 0, 10};
    tv[2]  = '{0, 0,    0, 125, 0, 10};
    tv[3]  = '{0, 0,    0, 0,   0, 10};
    // Channel isolation: ch0 impulse interleaved with ch1 zeros
    tv[4]  = '{0, 1000, 0, 500, 0, 10};
    tv[5]  = '{1, 0,    0, 0,   1, 10};
    tv[6]  = '{0, 0,    0, 250, 0, 10};
    tv[7]  = '{1, 0,    0, 0,   1, 10};
    tv[8]  = '{0, 0,    0, 125, 0, 10};
    tv[9]  = '{1, 0,    0, 0,   1, 10};
    tv[10] = '{0, 0,    0, 0,   0, 10};
    // Symmetric, c[0..4] = {512,0,0,0,1024}, ch0 impulse 800
    tv[11] = '{0, 800, 1, 200, 0, 6};
    tv[12] = '{0, 0,   1, 0,   0, 6};
    tv[13] = '{0, 0,   1, 0,   0, 6};
    tv[14] = '{0, 0,   1, 0,   0, 6};
    tv[15] = '{0, 0,   1, 400, 0, 6};
    tv[16] = '{0, 0,   1, 0,   0, 6};
    tv[17] = '{0, 0,   1, 0,   0, 6};
    tv[18] = '{0, 0,   1, 0,   0, 6};
    tv[19] = '{0, 0,   1, 200, 0, 6};
    // Saturation, c[0] = c[1] = 2047, on ch1
    tv[20] = '{1, 2047,  0, 2046,  1, 10};
    tv[21] = '{1, 2047,  0, 2047,  1, 10};
    tv[22] = '{1, -2048, 0, -1,    1, 10};
    tv[23] = '{1, -2048, 0, -2048, 1, 10};
    // Output rounding, c[0] = 1024, on ch1
`ifdef FIR_ROUND_EN
    tv[24] = '{1, 3,  0, 2,  1, 10};
    tv[25] = '{1, -3, 0, -1, 1, 10};
`else
    tv[24] = '{1, 3,  0, 1,  1, 10};
    tv[25] = '{1, -3, 0, -2, 1, 10};
`endif

    resetN = 1'b0; start = 1'b0; chSel = '0; x = '0; symCoeffs = 1'b0;
    lock = 1'b0; coeffLoadEn = 1'b0; coeffIn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_donech", int'(doneCh), 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    cbuf = {12'd1024, 12'd512, 12'd256, 72'd0};
    load_coeffs(cbuf);
    for (int i = 0; i <= 10; i++) run_vec(i, 0);

    // Start while busy: dropped with an overrun pulse, only one done.
    start = 1'b1; chSel = 1'b0; x = 12'd0; symCoeffs = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_mid", int'(busy), 1);
    start = 1'b1; chSel = 1'b1; x = 12'd555;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ovr_pulse", int'(overrun), 1);
    @(posedge clk); #1;
    chk("ovr_clear", int'(overrun), 0);
    count_dones(20, n);
    chk("ovr_single_done", n, 1);
    chk("ovr_y", int'($signed(y)), 0);

    // Start coincident with the done cycle is dropped too.
    do_start(0, 0, 0, 0, yo, co, lat);
    chk("coll_lat", lat, 10);
    chk("coll_busy_in_done", int'(busy), 1);
    start = 1'b1; chSel = 1'b1; x = 12'd555;
    @(posedge clk); #1;
    start = 1'b0;
    chk("coll_ovr", int'(overrun), 1);
    count_dones(20, n);
    chk("coll_no_done", n, 0);

    // Lock raised mid-MAC mutes that result only; the next one is normal.
    tv[0] = '{0, 1000, 0, 0, 0, 10};
    run_vec(0, 3);
    tv[0] = '{0, 0, 0, 250, 0, 10};
    run_vec(0, 0);

    // New coefficients shifted in under lock are used on the next start.
    cbuf = {12'd2047, 12'd2047, 84'd0};
    load_coeffs(cbuf);
    for (int i = 20; i <= 23; i++) run_vec(i, 0);

    // Reset in the middle of MAC: no done, outputs cleared.
    start = 1'b1; chSel = 1'b0; x = 12'd1000; symCoeffs = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetN = 1'b0;
    #2;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_y", int'($signed(y)), 0);
    chk("mrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    count_dones(20, n);
    chk("mrst_no_done", n, 0);

    cbuf = {12'd512, 12'd0, 12'd0, 12'd0, 12'd1024, 48'd0};
    load_coeffs(cbuf);
    for (int i = 11; i <= 19; i++) run_vec(i, 0);

    cbuf = {12'd1024, 96'd0};
    load_coeffs(cbuf);
    run_vec(24, 0);
    run_vec(25, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
